// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encodings, halt word and stream field widths.
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;

    localparam logic [WORD_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_HALT,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; byte k lands in bits [8k+7:8k].
// The completed word and its ready strobe are combinational on the 4th shift.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    localparam int unsigned HOLD_W = WORD_W - BYTE_W;

    logic [HOLD_W-1:0] data_q;
    logic [1:0]        cnt_q;

    // Only the three oldest bytes need storage; the 4th is taken straight from the input.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en_i) begin
            data_q <= {byte_i, data_q[HOLD_W-1:BYTE_W]};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign word_c       = {byte_i, data_q};
    assign word_ready_c = shift_en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, appends a halt word,
// and holds the processor in reset until the load has completed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [AW:0]       word_count
);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] len_lo_q, len_lo_d;
    logic [AW-1:0]     n_q, n_d;
    logic [AW:0]       wc_q, wc_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              xfer_c;
    logic              clear_c;
    logic              shift_c;
    logic [LEN_W-1:0]  len_full_c;
    logic [WORD_W-1:0] word_c;
    logic              word_ready_c;

    assign xfer_c     = byte_valid && ready_q;
    assign shift_c    = xfer_c && (state_q == ST_DATA);
    assign len_full_c = {byte_data, len_lo_q};
    assign clear_c    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERROR));

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_c),
        .shift_en_i   (shift_c),
        .byte_i       (byte_data),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        wc_d     = wc_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_LO;
                    wc_d    = '0;
                end
            end
            ST_LEN_LO: begin
                if (xfer_c) begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (xfer_c) begin
                    if (len_full_c > LEN_W'(DEPTH - 1)) begin
                        state_d = ST_ERROR;
                    end else begin
                        n_d     = AW'(len_full_c);
                        state_d = (len_full_c == '0) ? ST_HALT : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_ready_c) begin
                    we_d    = 1'b1;
                    addr_d  = wc_q[AW-1:0];
                    wdata_d = word_c;
                    wc_d    = wc_q + (AW+1)'(1);
                    if ((wc_q + (AW+1)'(1)) == {1'b0, n_q}) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                we_d    = 1'b1;
                addr_d  = n_q;
                wdata_d = HALT_WORD;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d     = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) || (state_d == ST_DATA);
        error_d     = (state_d == ST_ERROR);
        // done follows the halt-write cycle, and drops on the edge that accepts a restart.
        done_d      = (state_q == ST_DONE) && (state_d == ST_DONE);
        cpu_reset_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            n_q         <= '0;
            wc_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            n_q         <= n_d;
            wc_q        <= wc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_reset_q <= cpu_reset_d;
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as stimulus is
// issued and a negedge monitor pops and compares every imem_we strobe.
module tb_imem_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    logic          prev_we   = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (imem_we) begin
            if (prev_we) chk("we_single_pulse", 32'(imem_addr != prev_addr), 32'd1);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
        prev_we   <= imem_we;
        prev_addr <= imem_addr;
    end

    // All drive tasks start and end just after a negedge.
    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_ready_timeout: got 0 after %0d cycles, expected 1", w);
            byte_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    endtask

    task automatic wait_done(input int lim);
        int k;
        k = 0;
        while (!done && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", 32'(done), 32'd1);
        chk("cpu_reset_released", 32'(cpu_reset), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gap_bytes [6];
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);

        // Two-word program at full rate; done lands 12 edges after the start edge.
        push(8'd0, 32'h00A00513);
        push(8'd1, 32'h00B00593);
        push(8'd2, 32'h00000000);
        pulse_start();
        send(8'h02); send(8'h00);
        send_word(32'h00A00513);
        send_word(32'h00B00593);
        byte_valid = 1'b0;
        chk("n2_done_e10", 32'(done), 32'd0);
        @(negedge clk);
        chk("n2_done_e11", 32'(done), 32'd0);
        chk("n2_cpu_reset_e11", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        chk("n2_done_e12", 32'(done), 32'd1);
        chk("n2_cpu_reset_e12", 32'(cpu_reset), 32'd0);
        chk("n2_word_count", 32'(word_count), 32'd2);
        chk("n2_byte_ready", 32'(byte_ready), 32'd0);

        // Reload from DONE.
        pulse_start();
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("reload_word_count", 32'(word_count), 32'd0);
        chk("reload_byte_ready", 32'(byte_ready), 32'd1);
        push(8'd0, 32'h12345678);
        push(8'd1, 32'h00000000);
        send(8'h01); send(8'h00);
        send_word(32'h12345678);
        byte_valid = 1'b0;
        wait_done(10);
        chk("reload_word_count_end", 32'(word_count), 32'd1);

        // Empty program: only the halt word at address 0.
        push(8'd0, 32'h00000000);
        pulse_start();
        send(8'h00); send(8'h00);
        byte_valid = 1'b0;
        chk("n0_we_e2", 32'(imem_we), 32'd0);
        @(negedge clk);
        chk("n0_done_e3", 32'(done), 32'd0);
        @(negedge clk);
        chk("n0_done_e4", 32'(done), 32'd1);
        chk("n0_word_count", 32'(word_count), 32'd0);

        // One word with random gaps between bytes.
        gap_bytes = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push(8'd0, 32'hDEADBEEF);
        push(8'd1, 32'h00000000);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            idle(int'($urandom_range(0, 3)));
            send(gap_bytes[k]);
        end
        byte_valid = 1'b0;
        wait_done(20);
        chk("gap_word_count", 32'(word_count), 32'd1);

        // Length DEPTH exceeds capacity.
        pulse_start();
        send(8'h00); send(8'h01);
        byte_valid = 1'b0;
        chk("err_error", 32'(error), 32'd1);
        chk("err_byte_ready", 32'(byte_ready), 32'd0);
        chk("err_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("err_done", 32'(done), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        chk("err_error_held", 32'(error), 32'd1);
        chk("err_byte_ready_held", 32'(byte_ready), 32'd0);

        // Restart from ERROR, then reset after 6 bytes of a 3-word load.
        pulse_start();
        chk("err_restart_error", 32'(error), 32'd0);
        chk("err_restart_ready", 32'(byte_ready), 32'd1);
        push(8'd0, 32'h0A0B0C0D);
        send(8'h03); send(8'h00);
        send_word(32'h0A0B0C0D);
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_imem_we", 32'(imem_we), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        push(8'd0, 32'h11223344);
        push(8'd1, 32'h00000000);
        pulse_start();
        send(8'h01); send(8'h00);
        send_word(32'h11223344);
        byte_valid = 1'b0;
        wait_done(10);
        chk("postrst_word_count", 32'(word_count), 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
